// File: rtl/fetch_pkg.sv
// Shared widths, reset/step constants and the queue entry type for the fetch stage.
package fetch_pkg;

    localparam int ADDR_WIDTH  = 12;
    localparam int INSTR_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr} pairs with flush; head is presented from registers.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t push_data_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    fetch_entry_t mem_q [2];
    logic         head_q;
    logic         tail_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= push_data_i;
                tail_q        <= ~tail_q;
            end
            if (pop_i) begin
                head_q <= ~head_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// PC generation and I-mem request stage; returned reads are queued for fetch_buffer.
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = fetch_pkg::ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = fetch_pkg::INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = fetch_pkg::RESET_PC,
    parameter logic [ADDR_WIDTH-1:0] PC_STEP     = fetch_pkg::PC_STEP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_en,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic [INSTR_WIDTH-1:0] instr_out
);

    logic [ADDR_WIDTH-1:0] pc_req_q, pc_req_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                  inflight_q, inflight_d;

    fetch_pkg::fetch_entry_t push_data;
    fetch_pkg::fetch_entry_t head;
    logic [1:0]              count;
    logic                    head_vld;
    logic                    pop_req;
    logic [2:0]              occ;
    logic                    issue;

    assign head_vld = (count != 2'd0);
    assign pop_req  = head_vld && out_ready;

    // Occupancy counts the read in flight so a returning word always finds a free slot.
    assign occ   = {1'b0, count} + {2'b0, inflight_q};
    assign issue = !rst && !redirect_valid && (occ < (3'd2 + {2'b0, pop_req}));

    assign push_data.pc    = inflight_pc_q;
    assign push_data.instr = imem_rdata;

    fetch_queue u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (inflight_q && !redirect_valid),
        .pop_i       (pop_req && !redirect_valid),
        .push_data_i (push_data),
        .head_o      (head),
        .count_o     (count)
    );

    always_comb begin
        pc_req_d      = pc_req_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        if (redirect_valid) begin
            pc_req_d = redirect_pc;
        end else if (issue) begin
            pc_req_d      = pc_req_q + PC_STEP;
            inflight_pc_d = pc_req_q;
            inflight_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_req_q      <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            pc_req_q      <= pc_req_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    assign imem_en   = issue;
    assign imem_addr = pc_req_q;

    // Outputs are forced quiet while reset is held, regardless of stale queue contents.
    assign out_valid = !rst && head_vld;
    assign pc_out    = rst ? '0 : head.pc;
    assign instr_out = rst ? '0 : head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level queue model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        imem_en;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_ready;
    logic        out_valid;
    logic [11:0] pc_out;
    logic [31:0] instr_out;

    int nerr = 0;
    int nchk = 0;

    logic [11:0] m_pc;
    logic [11:0] m_q[$];
    logic [11:0] m_fly[$];
    logic [11:0] dlog[$];

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .pc_out         (pc_out),
        .instr_out      (instr_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous I-mem: one-cycle read latency, contents derived from the address.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= {20'h0, imem_addr} ^ 32'hA5A5_0000;
    end

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return {20'h0, a} ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step(input logic r, input logic rv, input logic [11:0] rp, input logic rdy);
        logic exp_ov;
        logic exp_en;
        logic pop;
        int   occ;
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        out_ready      = rdy;
        #1;
        exp_ov = !r && (m_q.size() != 0);
        pop    = exp_ov && rdy;
        occ    = m_q.size() + m_fly.size() - (pop ? 1 : 0);
        exp_en = !r && !rv && (occ < 2);
        check("out_valid", out_valid, exp_ov);
        check("imem_en", imem_en, exp_en);
        if (exp_en) check("imem_addr", imem_addr, m_pc);
        if (exp_ov) begin
            check("pc_out", pc_out, m_q[0]);
            check("instr_out", instr_out, mem_word(m_q[0]));
        end
        if (r) begin
            check("rst_pc_out", pc_out, 0);
            check("rst_instr_out", instr_out, 0);
        end
        if (out_valid && rdy && !rv && !r) dlog.push_back(pc_out);

        if (r) begin
            m_pc = 12'h000;
            m_q.delete();
            m_fly.delete();
        end else if (rv) begin
            m_pc = rp;
            m_q.delete();
            m_fly.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_fly.size() != 0) m_q.push_back(m_fly.pop_front());
            if (exp_en) begin
                m_fly.push_back(m_pc);
                m_pc = m_pc + 12'd4;
            end
        end
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'h000, rdy);
    endtask

    initial begin
        logic [11:0] rp;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        m_pc = 12'h000;

        step(1'b1, 1'b0, 12'h000, 1'b1);
        step(1'b1, 1'b0, 12'h000, 1'b1);

        // Sequential stream, then a 5-cycle downstream stall.
        dlog.delete();
        run(12, 1'b1);
        run(5, 1'b0);
        run(10, 1'b1);
        check("t1_len", dlog.size() >= 4, 1);
        if (dlog.size() >= 4) begin
            check("t1_pc0", dlog[0], 12'h000);
            check("t1_pc1", dlog[1], 12'h004);
            check("t1_pc2", dlog[2], 12'h008);
            check("t1_pc3", dlog[3], 12'h00C);
        end
        for (int i = 1; i < dlog.size(); i++) check("t2_seq", dlog[i], dlog[i-1] + 12'd4);

        // Redirect while the queue is full.
        run(3, 1'b0);
        dlog.delete();
        step(1'b0, 1'b1, 12'h100, 1'b1);
        run(6, 1'b1);
        check("t3_len", dlog.size() >= 2, 1);
        if (dlog.size() >= 2) begin
            check("t3_pc0", dlog[0], 12'h100);
            check("t3_pc1", dlog[1], 12'h104);
        end

        // Address wrap.
        dlog.delete();
        step(1'b0, 1'b1, 12'hFFC, 1'b1);
        run(8, 1'b1);
        check("t4_len", dlog.size() >= 3, 1);
        if (dlog.size() >= 3) begin
            check("t4_pc0", dlog[0], 12'hFFC);
            check("t4_pc1", dlog[1], 12'h000);
            check("t4_pc2", dlog[2], 12'h004);
        end

        // Redirect while the head is being offered with ready high; back-to-back redirect.
        dlog.delete();
        step(1'b0, 1'b1, 12'h300, 1'b1);
        step(1'b0, 1'b1, 12'h200, 1'b1);
        run(6, 1'b1);
        check("t5_len", dlog.size() >= 2, 1);
        if (dlog.size() >= 2) begin
            check("t5_pc0", dlog[0], 12'h200);
            check("t5_pc1", dlog[1], 12'h204);
        end

        // Mid-stream reset pulse.
        dlog.delete();
        step(1'b1, 1'b0, 12'h000, 1'b1);
        run(6, 1'b1);
        check("t6_len", dlog.size() >= 1, 1);
        if (dlog.size() >= 1) check("t6_pc0", dlog[0], 12'h000);

        // Random mix of backpressure, redirects and resets.
        for (int i = 0; i < 600; i++) begin
            rp = 12'($urandom);
            if ($urandom_range(0, 99) < 3)
                step(1'b1, 1'b0, 12'h000, 1'($urandom));
            else if ($urandom_range(0, 99) < 6)
                step(1'b0, 1'b1, rp, 1'($urandom));
            else
                step(1'b0, 1'b0, 12'h000, $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
